control_unit: RTL and testbench

- Instruction-sequencing FSM for the 8-bit computer.
- Drives every control input of the data path: register loads, PC increment, bus selects, ALU select and CCR load.
- Drives the memory write strobe.
- Reads back the instruction register and the NZVC condition codes.
- Sits beside the data path inside the computer top level; memory read latency is one clock.

---
 rtl/control_unit_pkg.sv | 78 +++++++
 rtl/control_unit_branch_cond.sv | 24 ++
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared constants for the 8-bit computer control unit: opcodes, ALU and bus select codes, states.
// The HLT state exists only when CU_HALT_EN is defined.
package control_unit_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned BUS_W   = 2;
  localparam int unsigned STATE_W = 5;

  localparam logic [OP_W-1:0] OP_LDA_IMM = 8'h86;
  localparam logic [OP_W-1:0] OP_LDA_DIR = 8'h87;
  localparam logic [OP_W-1:0] OP_LDB_IMM = 8'h88;
  localparam logic [OP_W-1:0] OP_LDB_DIR = 8'h89;
  localparam logic [OP_W-1:0] OP_STA_DIR = 8'h96;
  localparam logic [OP_W-1:0] OP_STB_DIR = 8'h97;
  localparam logic [OP_W-1:0] OP_ADD_AB  = 8'h42;
  localparam logic [OP_W-1:0] OP_SUB_AB  = 8'h43;
  localparam logic [OP_W-1:0] OP_AND_AB  = 8'h44;
  localparam logic [OP_W-1:0] OP_OR_AB   = 8'h45;
  localparam logic [OP_W-1:0] OP_INCA    = 8'h46;
  localparam logic [OP_W-1:0] OP_INCB    = 8'h47;
  localparam logic [OP_W-1:0] OP_DECA    = 8'h48;
  localparam logic [OP_W-1:0] OP_DECB    = 8'h49;
  localparam logic [OP_W-1:0] OP_BRA     = 8'h20;
  localparam logic [OP_W-1:0] OP_BMI     = 8'h21;
  localparam logic [OP_W-1:0] OP_BPL     = 8'h22;
  localparam logic [OP_W-1:0] OP_BEQ     = 8'h23;
  localparam logic [OP_W-1:0] OP_BNE     = 8'h24;
  localparam logic [OP_W-1:0] OP_BVS     = 8'h25;
  localparam logic [OP_W-1:0] OP_BVC     = 8'h26;
  localparam logic [OP_W-1:0] OP_BCS     = 8'h27;
  localparam logic [OP_W-1:0] OP_BCC     = 8'h28;
  localparam logic [OP_W-1:0] OP_HALT    = 8'hFF;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_INCA = 3'b100;
  localparam logic [ALU_W-1:0] ALU_DECA = 3'b101;
  localparam logic [ALU_W-1:0] ALU_INCB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_DECB = 3'b111;

  localparam logic [BUS_W-1:0] BUS1_PC   = 2'b00;
  localparam logic [BUS_W-1:0] BUS1_A    = 2'b01;
  localparam logic [BUS_W-1:0] BUS1_B    = 2'b10;
  localparam logic [BUS_W-1:0] BUS2_ALU  = 2'b00;
  localparam logic [BUS_W-1:0] BUS2_BUS1 = 2'b01;
  localparam logic [BUS_W-1:0] BUS2_MEM  = 2'b10;

  // LI = immediate load, LD = direct load, ST = direct store, BT/BN = branch taken/not taken
  typedef enum logic [STATE_W-1:0] {
    S_F0, S_F1, S_F2, S_D3,
    S_LI4, S_LI5, S_LI6,
    S_LD4, S_LD5, S_LD6, S_LD7, S_LD8,
    S_ST4, S_ST5, S_ST6, S_ST7,
    S_ALU4,
    S_BT4, S_BT5, S_BT6,
    S_BN4
`ifdef CU_HALT_EN
    , S_HLT
`endif
  } state_t;

  function automatic logic [ALU_W-1:0] alu_sel_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB_AB: return ALU_SUB;
      OP_AND_AB: return ALU_AND;
      OP_OR_AB:  return ALU_OR;
      OP_INCA:   return ALU_INCA;
      OP_DECA:   return ALU_DECA;
      OP_INCB:   return ALU_INCB;
      OP_DECB:   return ALU_DECB;
      default:   return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch condition evaluator: low opcode nibble selects a test on the NZVC flags.
module control_unit_branch_cond (
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      4'h0: taken_c = 1'b1;
      4'h1: taken_c = nzvc[3];
      4'h2: taken_c = ~nzvc[3];
      4'h3: taken_c = nzvc[2];
      4'h4: taken_c = ~nzvc[2];
      4'h5: taken_c = nzvc[1];
      4'h6: taken_c = ~nzvc[1];
      4'h7: taken_c = nzvc[0];
      4'h8: taken_c = ~nzvc[0];
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the 8-bit computer; Moore outputs decoded from state and IR.
// Optional HALT opcode enabled by defining CU_HALT_EN.
module control_unit
  import control_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [OP_W-1:0]  IR,
  input  logic [3:0]       CCR_Result,
  output logic             IR_Load,
  output logic             MAR_Load,
  output logic             PC_Load,
  output logic             PC_Inc,
  output logic             A_Load,
  output logic             B_Load,
  output logic             CCR_Load,
  output logic [BUS_W-1:0] Bus1_Sel,
  output logic [BUS_W-1:0] Bus2_Sel,
  output logic [ALU_W-1:0] ALU_Sel,
  output logic             write,
  output logic             halted
);

  state_t state, state_nx;
  logic   br_taken_c;

  control_unit_branch_cond u_branch_cond (
    .cond    (IR[3:0]),
    .nzvc    (CCR_Result),
    .taken_c (br_taken_c)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_F0;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_F0:  state_nx = S_F1;
      S_F1:  state_nx = S_F2;
      S_F2:  state_nx = S_D3;
      S_D3: begin
        case (IR)
          OP_LDA_IMM, OP_LDB_IMM: state_nx = S_LI4;
          OP_LDA_DIR, OP_LDB_DIR: state_nx = S_LD4;
          OP_STA_DIR, OP_STB_DIR: state_nx = S_ST4;
          OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
          OP_INCA, OP_DECA, OP_INCB, OP_DECB: state_nx = S_ALU4;
          OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
          OP_BVS, OP_BVC, OP_BCS, OP_BCC: state_nx = br_taken_c ? S_BT4 : S_BN4;
`ifdef CU_HALT_EN
          OP_HALT: state_nx = S_HLT;
`endif
          default: state_nx = S_F0;
        endcase
      end
      S_LI4: state_nx = S_LI5;
      S_LI5: state_nx = S_LI6;
      S_LD4: state_nx = S_LD5;
      S_LD5: state_nx = S_LD6;
      S_LD6: state_nx = S_LD7;
      S_LD7: state_nx = S_LD8;
      S_ST4: state_nx = S_ST5;
      S_ST5: state_nx = S_ST6;
      S_ST6: state_nx = S_ST7;
      S_BT4: state_nx = S_BT5;
      S_BT5: state_nx = S_BT6;
`ifdef CU_HALT_EN
      S_HLT: state_nx = S_HLT;
`endif
      default: state_nx = S_F0;
    endcase
  end

  // Reset gates the decode so every output is idle while Reset is low, even though state is F0.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    ALU_Sel  = ALU_ADD;
    write    = 1'b0;
`ifdef CU_HALT_EN
    halted   = 1'b0;
`endif
    if (Reset) begin
      case (state)
        S_F0, S_LI4, S_LD4, S_ST4, S_BT4: begin
          Bus1_Sel = BUS1_PC;
          Bus2_Sel = BUS2_BUS1;
          MAR_Load = 1'b1;
        end
        S_F1, S_LI5, S_LD5, S_ST5, S_BN4: PC_Inc = 1'b1;
        S_F2: begin
          Bus2_Sel = BUS2_MEM;
          IR_Load  = 1'b1;
        end
        S_LI6, S_LD8: begin
          Bus2_Sel = BUS2_MEM;
          A_Load   = (IR == OP_LDA_IMM) || (IR == OP_LDA_DIR);
          B_Load   = (IR == OP_LDB_IMM) || (IR == OP_LDB_DIR);
        end
        S_LD6, S_ST6: begin
          Bus2_Sel = BUS2_MEM;
          MAR_Load = 1'b1;
        end
        S_ST7: begin
          Bus1_Sel = (IR == OP_STA_DIR) ? BUS1_A : BUS1_B;
          write    = 1'b1;
        end
        S_ALU4: begin
          Bus1_Sel = BUS1_A;
          Bus2_Sel = BUS2_ALU;
          ALU_Sel  = alu_sel_of(IR);
          CCR_Load = 1'b1;
          B_Load   = (IR == OP_INCB) || (IR == OP_DECB);
          A_Load   = ~((IR == OP_INCB) || (IR == OP_DECB));
        end
        S_BT6: begin
          Bus2_Sel = BUS2_MEM;
          PC_Load  = 1'b1;
        end
`ifdef CU_HALT_EN
        S_HLT: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifndef CU_HALT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control words queued per instruction.
module tb_control_unit;

  typedef struct packed {
    logic       ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld, ccr_ld;
    logic [1:0] bus1, bus2;
    logic [2:0] alu;
    logic       wr, hlt;
  } ctl_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write, halted;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [2:0] ALU_Sel;

  ctl_t obs;
  ctl_t sb[$];
  int   total = 0;
  int   bad   = 0;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .ALU_Sel(ALU_Sel),
    .write(write), .halted(halted)
  );

  assign obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                Bus1_Sel, Bus2_Sel, ALU_Sel, write, halted};

  always #5 Clk = ~Clk;

  function automatic ctl_t mar_pc();
    ctl_t c = '0;
    c.mar_ld = 1'b1; c.bus1 = 2'b00; c.bus2 = 2'b01;
    return c;
  endfunction

  function automatic ctl_t inc();
    ctl_t c = '0;
    c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t mem();
    ctl_t c = '0;
    c.bus2 = 2'b10;
    return c;
  endfunction

  function automatic bit br_taken(input logic [7:0] op, input logic [3:0] f);
    case (op)
      8'h20: return 1'b1;
      8'h21: return f[3];
      8'h22: return !f[3];
      8'h23: return f[2];
      8'h24: return !f[2];
      8'h25: return f[1];
      8'h26: return !f[1];
      8'h27: return f[0];
      8'h28: return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag);
    ctl_t exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag);
    #1 check(tag);
    @(negedge Clk);
  endtask

  task automatic push_fetch();
    ctl_t c;
    sb.push_back(mar_pc());
    sb.push_back(inc());
    c = mem(); c.ir_ld = 1'b1;
    sb.push_back(c);
    sb.push_back('0);
  endtask

  // Queue the expected word for every cycle of one instruction, then check each cycle.
  task automatic run(input logic [7:0] op, input logic [3:0] ccr, input string tag);
    ctl_t c;
    int   n;
    IR = op;
    CCR_Result = ccr;
    push_fetch();
    if (op == 8'h86 || op == 8'h88) begin
      sb.push_back(mar_pc()); sb.push_back(inc());
      c = mem(); c.a_ld = (op == 8'h86); c.b_ld = (op == 8'h88); sb.push_back(c);
    end else if (op == 8'h87 || op == 8'h89) begin
      sb.push_back(mar_pc()); sb.push_back(inc());
      c = mem(); c.mar_ld = 1'b1; sb.push_back(c);
      sb.push_back('0);
      c = mem(); c.a_ld = (op == 8'h87); c.b_ld = (op == 8'h89); sb.push_back(c);
    end else if (op == 8'h96 || op == 8'h97) begin
      sb.push_back(mar_pc()); sb.push_back(inc());
      c = mem(); c.mar_ld = 1'b1; sb.push_back(c);
      c = '0; c.wr = 1'b1; c.bus1 = (op == 8'h96) ? 2'b01 : 2'b10; sb.push_back(c);
    end else if (op >= 8'h42 && op <= 8'h49) begin
      c = '0; c.bus1 = 2'b01; c.bus2 = 2'b00; c.ccr_ld = 1'b1;
      case (op)
        8'h42: c.alu = 3'b000;
        8'h43: c.alu = 3'b001;
        8'h44: c.alu = 3'b010;
        8'h45: c.alu = 3'b011;
        8'h46: c.alu = 3'b100;
        8'h48: c.alu = 3'b101;
        8'h47: c.alu = 3'b110;
        default: c.alu = 3'b111;
      endcase
      c.b_ld = (op == 8'h47 || op == 8'h49);
      c.a_ld = !c.b_ld;
      sb.push_back(c);
    end else if (op >= 8'h20 && op <= 8'h28) begin
      if (br_taken(op, ccr)) begin
        sb.push_back(mar_pc()); sb.push_back('0);
        c = mem(); c.pc_ld = 1'b1; sb.push_back(c);
      end else begin
        sb.push_back(inc());
      end
    end
    n = sb.size();
    repeat (n) step(tag);
  endtask

  initial begin
    ctl_t c;
    Reset = 1'b0;
    IR = 8'h00;
    CCR_Result = 4'h0;
    repeat (2) @(negedge Clk);
    sb.push_back('0);
    #1 check("reset_idle");
    @(negedge Clk);
    Reset = 1'b1;

    run(8'h86, 4'h0, "lda_imm");
    run(8'h88, 4'h0, "ldb_imm");
    run(8'h87, 4'h0, "lda_dir");
    run(8'h89, 4'h0, "ldb_dir");
    run(8'h96, 4'h0, "sta_dir");
    run(8'h97, 4'h0, "stb_dir");
    for (int op = 8'h42; op <= 8'h49; op++) run(8'(op), 4'h0, "alu");
    run(8'h23, 4'b0100, "beq_taken");
    run(8'h23, 4'b0000, "beq_not");
    run(8'h20, 4'b0000, "bra");
    run(8'h21, 4'b1000, "bmi_taken");
    run(8'h22, 4'b1000, "bpl_not");
    run(8'h24, 4'b0000, "bne_taken");
    run(8'h25, 4'b0010, "bvs_taken");
    run(8'h26, 4'b0010, "bvc_not");
    run(8'h27, 4'b0000, "bcs_not");
    run(8'h28, 4'b0000, "bcc_taken");
    run(8'h00, 4'h0, "undef_00");
    run(8'h29, 4'hF, "undef_29");
    run(8'h4A, 4'h0, "undef_4a");

`ifdef CU_HALT_EN
    IR = 8'hFF;
    push_fetch();
    c = '0; c.hlt = 1'b1;
    repeat (20) sb.push_back(c);
    repeat (24) step("halt");
    #2 Reset = 1'b0;
    sb.push_back('0);
    #1 check("halt_reset");
    @(negedge Clk);
    Reset = 1'b1;
`else
    run(8'hFF, 4'h0, "ff_nop");
`endif

    // Reset asserted in the middle of the STA_DIR write cycle.
    IR = 8'h96;
    push_fetch();
    sb.push_back(mar_pc()); sb.push_back(inc());
    c = mem(); c.mar_ld = 1'b1; sb.push_back(c);
    repeat (7) step("sta_pre");
    c = '0; c.wr = 1'b1; c.bus1 = 2'b01; sb.push_back(c);
    #1 check("sta_e7");
    #2 Reset = 1'b0;
    sb.push_back('0);
    #1 check("rst_mid_e7");
    @(negedge Clk);
    Reset = 1'b1;
    sb.push_back(mar_pc());
    step("after_rst_f0");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain left=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
